route_scheduler: RTL and testbench

//  Arbiter/sequencer for the shared 4-bit source-mux / destination-demux routing path.
//  Two requesters (X, Y) compete for the path; the block grants round-robin and drives the select lines.
//  It inserts a turnaround gap whenever the selects change and registers the routed beat onto the right/left outputs.
//  It sits between the requesting logic and the right/left consumers and is the only driver of the selects.

---
 rtl/route_pkg.sv | 14 +
 rtl/rr_arb2.sv | 23 ++
 rtl/route_scheduler.sv | 120 ++++++++++++
 tb/tb_route_scheduler.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/route_pkg.sv
// Shared encodings for the routing-path scheduler.
// State codes plus source/destination select values.
package route_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_TURN = 2'd1;
   localparam logic [1:0] ST_XFER = 2'd2;

   localparam logic SRC_X     = 1'b0;
   localparam logic SRC_Y     = 1'b1;
   localparam logic DST_RIGHT = 1'b0;
   localparam logic DST_LEFT  = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin picker.
// On a tie the requester that did not win last time is chosen.
module rr_arb2
   import route_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant,
   output logic       grant_valid
);

   // Pick the lone requester, or alternate on a tie
   always_comb begin
      grant_valid = |req;
      if (&req)
         grant = ~last_grant;
      else if (req[SRC_Y])
         grant = SRC_Y;
      else
         grant = SRC_X;
   end

endmodule

// File: rtl/route_scheduler.sv
// Arbiter/sequencer for the shared source-mux / destination-demux path.
// Grants X/Y round-robin, inserts a turnaround gap, registers routed beats.
module route_scheduler
   import route_pkg::*;
#(
   parameter int WIDTH     = 4,
   parameter int BURST_MAX = 4,
   parameter int TURN      = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             x_req,
   input  logic             x_dest,
   input  logic [WIDTH-1:0] x_data,
   output logic             x_ack,
   input  logic             y_req,
   input  logic             y_dest,
   input  logic [WIDTH-1:0] y_data,
   output logic             y_ack,
   output logic             sel_src,
   output logic             sel_dst,
   output logic [WIDTH-1:0] right_data,
   output logic             right_valid,
   output logic [WIDTH-1:0] left_data,
   output logic             left_valid,
   output logic             busy
);

   localparam int BW = $clog2(BURST_MAX + 1);
   localparam int TW = $clog2(TURN + 1);

   logic [1:0]       state;
   logic [BW-1:0]    beat_cnt;
   logic [TW-1:0]    turn_cnt;
   logic             last_grant;
   logic             grant;
   logic             grant_valid;
   logic             g_req;
   logic             g_dest;
   logic [WIDTH-1:0] g_data;
   logic             ack;
   logic             beat_last;
   logic             turn_done;

   rr_arb2 u_arb (
      .req         ({y_req, x_req}),
      .last_grant  (last_grant),
      .grant       (grant),
      .grant_valid (grant_valid)
   );

   // Grantee view of the request lines and the transfer handshake
   always_comb begin
      g_req     = (sel_src == SRC_Y) ? y_req  : x_req;
      g_dest    = (sel_src == SRC_Y) ? y_dest : x_dest;
      g_data    = (sel_src == SRC_Y) ? y_data : x_data;
      ack       = (state == ST_XFER) && g_req && (g_dest == sel_dst);
      x_ack     = ack && (sel_src == SRC_X);
      y_ack     = ack && (sel_src == SRC_Y);
      beat_last = (beat_cnt == BW'(BURST_MAX - 1));
      turn_done = (turn_cnt == TW'(TURN - 1));
      busy      = (state != ST_IDLE);
   end

   // FSM, counters, selects and registered output beats
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         sel_src     <= SRC_X;
         sel_dst     <= DST_RIGHT;
         last_grant  <= SRC_Y;
         beat_cnt    <= '0;
         turn_cnt    <= '0;
         right_data  <= '0;
         right_valid <= 1'b0;
         left_data   <= '0;
         left_valid  <= 1'b0;
      end else begin
         right_valid <= 1'b0;
         left_valid  <= 1'b0;
         unique case (state)
            ST_IDLE: begin
               if (grant_valid) begin
                  sel_src    <= grant;
                  sel_dst    <= (grant == SRC_Y) ? y_dest : x_dest;
                  last_grant <= grant;
                  turn_cnt   <= '0;
                  state      <= ST_TURN;
               end
            end
            ST_TURN: begin
               if (turn_cnt != TW'(TURN))
                  turn_cnt <= turn_cnt + TW'(1);
               if (turn_done) begin
                  beat_cnt <= '0;
                  state    <= ST_XFER;
               end
            end
            ST_XFER: begin
               if (ack) begin
                  if (sel_dst == DST_LEFT) begin
                     left_data  <= g_data;
                     left_valid <= 1'b1;
                  end else begin
                     right_data  <= g_data;
                     right_valid <= 1'b1;
                  end
                  beat_cnt <= beat_cnt + BW'(1);
                  if (beat_last)
                     state <= ST_IDLE;
               end else begin
                  state <= ST_IDLE;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_route_scheduler.sv
// Randomized scoreboard bench for route_scheduler.
// A transaction-level model predicts acks; a monitor checks routed beats.
module tb_route_scheduler;

   localparam int W  = 4;
   localparam int BM = 4;
   localparam int TN = 1;

   logic         clk;
   logic         rst;
   logic         x_req, x_dest, x_ack;
   logic [W-1:0] x_data;
   logic         y_req, y_dest, y_ack;
   logic [W-1:0] y_data;
   logic         sel_src, sel_dst;
   logic [W-1:0] right_data, left_data;
   logic         right_valid, left_valid;
   logic         busy;

   route_scheduler #(.WIDTH(W), .BURST_MAX(BM), .TURN(TN)) dut (
      .clk         (clk),
      .rst         (rst),
      .x_req       (x_req),
      .x_dest      (x_dest),
      .x_data      (x_data),
      .x_ack       (x_ack),
      .y_req       (y_req),
      .y_dest      (y_dest),
      .y_data      (y_data),
      .y_ack       (y_ack),
      .sel_src     (sel_src),
      .sel_dst     (sel_dst),
      .right_data  (right_data),
      .right_valid (right_valid),
      .left_data   (left_data),
      .left_valid  (left_valid),
      .busy        (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic         dest;
      logic [W-1:0] data;
      int           stamp;
   } beat_t;

   beat_t sbq[$];
   int    checks   = 0;
   int    failures = 0;
   int    cyc      = 0;
   bit    took_x, took_y;

   task automatic chk(input string name, input int got, input int exp);
      checks++;
      if (got != exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, got, exp, cyc);
      end
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   // Reference model: owner of the path, turnaround left, beats sent
   int owner     = -1;
   int last      = 1;
   int wait_left = 0;
   int beats     = 0;
   bit dsel      = 0;
   bit rst_seen  = 0;

   always @(negedge clk) begin
      bit   rq[2];
      bit   ds[2];
      logic [W-1:0] dt[2];
      bit   ex[2];
      bit   ok;
      int   p;
      rq[0] = x_req; rq[1] = y_req;
      ds[0] = x_dest; ds[1] = y_dest;
      dt[0] = x_data; dt[1] = y_data;
      ex[0] = 0; ex[1] = 0;
      if (rst) begin
         owner = -1; last = 1; wait_left = 0; beats = 0;
         rst_seen = 1;
      end else begin
         if (rst_seen) begin
            chk("rst_busy", busy, 0);
            chk("rst_sel", {sel_src, sel_dst}, 0);
            chk("rst_valid", {right_valid, left_valid}, 0);
            chk("rst_data", {right_data, left_data}, 0);
            rst_seen = 0;
         end
         chk("busy", busy, owner >= 0);
         if (owner < 0) begin
            if (rq[0] || rq[1]) begin
               p = (rq[0] && rq[1]) ? 1 - last : (rq[1] ? 1 : 0);
               owner = p; last = p; dsel = ds[p];
               wait_left = TN; beats = 0;
            end
         end else begin
            chk("sel", {sel_src, sel_dst}, {owner[0], dsel});
            if (wait_left > 0) begin
               wait_left--;
            end else begin
               p  = owner;
               ok = rq[p] && (ds[p] == dsel);
               if (ok) begin
                  ex[p] = 1;
                  sbq.push_back('{dest: dsel, data: dt[p], stamp: cyc});
                  beats++;
               end
               if (!ok || beats == BM) begin
                  owner = -1; beats = 0;
               end
            end
         end
         chk("ack", {x_ack, y_ack}, {ex[0], ex[1]});
      end
      took_x = x_ack;
      took_y = y_ack;
   end

   // Monitor: every routed strobe must match the oldest accepted beat
   always @(negedge clk) begin
      beat_t b;
      if (right_valid || left_valid) begin
         chk("no_overlap", right_valid && left_valid, 0);
         if (sbq.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            b = sbq.pop_front();
            chk("out_dest", left_valid, b.dest);
            chk("out_data", left_valid ? left_data : right_data, b.data);
            chk("out_latency", cyc - 1, b.stamp);
         end
      end
   end

   task automatic next_beat(input int i, input bit soak);
      logic [W-1:0] d;
      bit dst;
      d   = W'($urandom);
      dst = soak ? (i == 1) : bit'($urandom_range(0, 1));
      if (i == 0) begin x_data = d; x_dest = dst; end
      else        begin y_data = d; y_dest = dst; end
   endtask

   task automatic drive_rand(input int i, input bit took);
      bit r;
      r = (i == 0) ? x_req : y_req;
      if (took) begin
         r = $urandom_range(0, 3) != 0;
         next_beat(i, 0);
      end else if (!r) begin
         r = $urandom_range(0, 2) == 0;
         if (r) next_beat(i, 0);
      end else if ($urandom_range(0, 15) == 0) begin
         r = 0;
      end
      if (i == 0) x_req = r; else y_req = r;
   endtask

   initial begin
      rst = 1; x_req = 0; y_req = 0;
      x_dest = 0; y_dest = 0; x_data = '0; y_data = '0;
      repeat (3) @(posedge clk);
      #1;
      rst = 0;
      x_req = 1; x_dest = 1; x_data = 4'hA;
      for (int c = 0; c < 600; c++) begin
         @(posedge clk);
         #1;
         rst = 0;
         if (c < 6) begin
            if (took_x) x_req = 0;
         end else if (c < 70) begin
            if (c == 6) begin
               x_req = 1; y_req = 1;
               next_beat(0, 1); next_beat(1, 1);
            end else begin
               if (took_x) next_beat(0, 1);
               if (took_y) next_beat(1, 1);
            end
         end else if (c == 250 || c == 420) begin
            rst = 1; x_req = 0; y_req = 0;
         end else begin
            drive_rand(0, took_x);
            drive_rand(1, took_y);
         end
      end
      @(posedge clk);
      #1;
      x_req = 0; y_req = 0;
      repeat (12) @(posedge clk);
      @(negedge clk);
      chk("sb_empty", sbq.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
